bcd_xy_entry: RTL
=================

Name: bcd_xy_entry

Overview:
- Inverse of the coordinate-to-decimal display path: the user enters X and Y coordinates as decimal digits using switches and keys, and the block converts them to 8-bit binary.
- The BCD digits currently being entered are output so the 7-seg drivers can show them while the user types.
- A commit converts both axes with an iterative multiply-by-10 accumulator and presents saturated binary X/Y to the draw/putpixel logic with a one-cycle valid pulse.
- Sits between the board KEY/SW inputs and the pixel-write mux, running in the 40 MHz pixel clock domain.

Parameters:
- OUT_W, 8, width of the binary coordinate outputs.
- MAX_X, 255, X saturation limit; must be < 2^OUT_W.
- MAX_Y, 255, Y saturation limit; must be < 2^OUT_W.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- digit_in  in  4  digit value from SW[3:0]; values 10..15 clamp to 9.
- key_n  in  3  raw active-low keys: [0] shift digit in, [1] toggle axis, [2] commit.
- axis_sel  out  1  axis being edited: 0 = X, 1 = Y.
- x_bcd  out  12  X digits {hundreds, tens, ones}.
- y_bcd  out  12  Y digits {hundreds, tens, ones}.
- x_out  out  OUT_W  last converted X.
- y_out  out  OUT_W  last converted Y.
- valid  out  1  one-cycle pulse when x_out/y_out update.
- busy  out  1  high while a conversion is in progress.
- sat  out  1  last conversion clamped at least one axis.

Behaviour:
- Reset (sampled on the clk edge with rst=1): every output goes to 0. The FSM enters IDLE. All synchronizer and edge-detect flops go to 1 (released key level).
- Key path, per key:
  - Two-flop synchronizer followed by a previous-level flop.
  - strobe = prev & ~sync, so each falling press yields exactly one strobe.
  - Holding a key gives no repeat. The release edge gives no strobe.
- Digit entry, in IDLE only:
  - A shift strobe shifts the selected axis left one digit: {d1, d0, clamp(digit_in)}. The old hundreds digit is discarded.
  - A toggle strobe inverts axis_sel.
- Simultaneous strobes in the same cycle:
  - Commit wins; shift and toggle are dropped.
  - Shift together with toggle: the shift applies to the pre-toggle axis, and the toggle also applies.
- FSM states: IDLE, CX, CY, DONE.
  - IDLE -> CX on a commit strobe (call its cycle S). acc is cleared and idx is set to 2.
  - CX (cycles S+1..S+3): each cycle, acc <= acc*10 + x digit[idx], computed as (acc<<3) + (acc<<1) + digit; idx decrements.
  - After idx 0 in CX: latch the X result, then go to CY with acc cleared and idx = 2.
  - CY (cycles S+4..S+6): the same iteration on the y digits.
  - CY -> DONE after idx 0.
  - DONE (cycle S+7): x_out/y_out are registered, valid=1, sat is updated. The next state is IDLE.
- busy is high in CX, CY and DONE.
- All strobes are ignored while busy. Digits and axis_sel are frozen during conversion.
- Arithmetic:
  - acc is 10 bits wide, enough for a maximum of 999.
  - Saturation: result = (acc > MAX) ? MAX : acc[OUT_W-1:0].
  - sat = X clamped OR Y clamped. It is recomputed on every commit; it is not sticky across commits.
- Outputs hold their values between commits. valid is high only in DONE.
- Back-to-back: a commit strobe arriving in DONE is ignored. A commit at S+8 or later starts a new conversion.
- Reset mid-conversion: returns to IDLE immediately. No valid pulse is produced, and outputs and digits are cleared.

Test Plan:
- Reset -> all outputs 0, axis_sel=0, busy=0. Hold key_n=3'b111 for 20 cycles -> no change.
- Normal conversion:
  - X: shift 1, 2, 3. Toggle. Y: shift 0, 4, 5.
  - Expect x_bcd=12'h123, y_bcd=12'h045.
  - Commit at strobe S -> busy from S+1 to S+7; valid only at S+7; x_out=123, y_out=45, sat=0.
- Saturation and clamping:
  - X digits 9, 9, 9 -> x_out=255, sat=1.
  - digit_in=4'hC shifted in -> digit stored as 9.
  - With MAX_X=199 and X=200 -> x_out=199, sat=1.
- Keys while busy:
  - Shift/toggle/commit strobes during S+1..S+7 -> digits, axis_sel unchanged; exactly one valid pulse.
  - Key held low 100 cycles -> exactly one shift.
- Simultaneous strobes:
  - Shift + toggle with axis_sel=0 -> digit lands in X, axis_sel=1.
  - Commit + shift -> conversion starts, digits unchanged.
- Reset at S+4 -> next cycle busy=0, x_out=0, no valid pulse. A later commit of 0,0,7 gives x_out=7.

Source files
------------

// File: rtl/bcd_xy_entry_if.sv
// rtl/bcd_xy_entry_if.sv - key/switch entry and converted-coordinate bundle for bcd_xy_entry
// Ports (slave = entry block side):
//   digit_in  in  4      digit value from switches (10..15 clamp to 9)
//   key_n     in  3      raw active-low keys: [0] shift, [1] toggle axis, [2] commit
//   axis_sel  out 1      axis being edited (0 = X, 1 = Y)
//   x_bcd     out 12     X digits {hundreds, tens, ones}
//   y_bcd     out 12     Y digits {hundreds, tens, ones}
//   x_out     out OUT_W  last converted X
//   y_out     out OUT_W  last converted Y
//   valid     out 1      one-cycle pulse when x_out/y_out update
//   busy      out 1      conversion in progress
//   sat       out 1      last conversion clamped at least one axis
interface bcd_xy_entry_if #(
  parameter int OUT_W = 8
);
  logic [3:0]       digit_in;
  logic [2:0]       key_n;
  logic             axis_sel;
  logic [11:0]      x_bcd;
  logic [11:0]      y_bcd;
  logic [OUT_W-1:0] x_out;
  logic [OUT_W-1:0] y_out;
  logic             valid;
  logic             busy;
  logic             sat;

  modport master (
    output digit_in, key_n,
    input  axis_sel, x_bcd, y_bcd, x_out, y_out, valid, busy, sat
  );

  modport slave (
    input  digit_in, key_n,
    output axis_sel, x_bcd, y_bcd, x_out, y_out, valid, busy, sat
  );
endinterface

// File: rtl/bcd_xy_entry.sv
// rtl/bcd_xy_entry.sv - decimal X/Y coordinate entry with iterative BCD-to-binary conversion
// Ports:
//   clk    in     pixel clock, single domain
//   rst    in     synchronous active-high reset
//   io_bus slave  key/switch inputs, live BCD digits, converted X/Y with valid/busy/sat
module bcd_xy_entry #(
  parameter int OUT_W = 8,
  parameter int MAX_X = 255,
  parameter int MAX_Y = 255
) (
  input  logic          clk,
  input  logic          rst,
  bcd_xy_entry_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CX,
    ST_CY,
    ST_DONE
  } state_t;

  localparam logic [9:0]       MAX_X_ACC = 10'(MAX_X);
  localparam logic [9:0]       MAX_Y_ACC = 10'(MAX_Y);
  localparam logic [OUT_W-1:0] MAX_X_OUT = OUT_W'(MAX_X);
  localparam logic [OUT_W-1:0] MAX_Y_OUT = OUT_W'(MAX_Y);

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_prev;
  logic [2:0]       w_stb;
  logic             r_axis;
  logic [11:0]      r_x_bcd;
  logic [11:0]      r_y_bcd;
  logic [9:0]       r_acc;
  logic [1:0]       r_idx;
  logic [OUT_W-1:0] r_x_res;
  logic             r_x_sat;
  logic [OUT_W-1:0] r_x_out;
  logic [OUT_W-1:0] r_y_out;
  logic             r_sat;
  logic [3:0]       w_digit_clamped;
  logic [3:0]       w_digit;
  logic [11:0]      w_bcd_sel;
  logic [9:0]       w_acc_next;
  logic             w_over;
  logic [OUT_W-1:0] w_res;

  // One strobe per press: falling edge of the synchronized key level.
  assign w_stb = r_prev & ~r_sync2;

  assign w_digit_clamped = (io_bus.digit_in > 4'd9) ? 4'd9 : io_bus.digit_in;

  // Digit feeding the accumulator: hundreds first (idx 2), ones last (idx 0).
  always_comb begin
    w_bcd_sel = (r_state == ST_CY) ? r_y_bcd : r_x_bcd;
    w_digit   = w_bcd_sel[3:0];
    case (r_idx)
      2'd2:    w_digit = w_bcd_sel[11:8];
      2'd1:    w_digit = w_bcd_sel[7:4];
      default: w_digit = w_bcd_sel[3:0];
    endcase
  end

  // acc*10 + digit without a multiplier; acc <= 99 here so 10 bits never overflow.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {6'd0, w_digit};

  always_comb begin
    w_over = 1'b0;
    w_res  = w_acc_next[OUT_W-1:0];
    if (r_state == ST_CY) begin
      w_over = (w_acc_next > MAX_Y_ACC);
      if (w_over) w_res = MAX_Y_OUT;
    end else begin
      w_over = (w_acc_next > MAX_X_ACC);
      if (w_over) w_res = MAX_X_OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_stb[2]) w_state_next = ST_CX;
      ST_CX:   if (r_idx == 2'd0) w_state_next = ST_CY;
      ST_CY:   if (r_idx == 2'd0) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
      r_prev  <= 3'b111;
      r_axis  <= 1'b0;
      r_x_bcd <= 12'd0;
      r_y_bcd <= 12'd0;
      r_acc   <= 10'd0;
      r_idx   <= 2'd0;
      r_x_res <= '0;
      r_x_sat <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_sync1 <= io_bus.key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        ST_IDLE: begin
          if (w_stb[2]) begin
            // Commit wins over any shift/toggle landing in the same cycle.
            r_acc <= 10'd0;
            r_idx <= 2'd2;
          end else begin
            // Shift uses the pre-toggle axis when both strobe together.
            if (w_stb[0]) begin
              if (r_axis) r_y_bcd <= {r_y_bcd[7:0], w_digit_clamped};
              else        r_x_bcd <= {r_x_bcd[7:0], w_digit_clamped};
            end
            if (w_stb[1]) r_axis <= ~r_axis;
          end
        end
        ST_CX: begin
          if (r_idx == 2'd0) begin
            r_x_res <= w_res;
            r_x_sat <= w_over;
            r_acc   <= 10'd0;
            r_idx   <= 2'd2;
          end else begin
            r_acc <= w_acc_next;
            r_idx <= r_idx - 2'd1;
          end
        end
        ST_CY: begin
          if (r_idx == 2'd0) begin
            // Outputs change on entry to DONE so they coincide with valid.
            r_x_out <= r_x_res;
            r_y_out <= w_res;
            r_sat   <= r_x_sat | w_over;
          end else begin
            r_acc <= w_acc_next;
            r_idx <= r_idx - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.axis_sel = r_axis;
  assign io_bus.x_bcd    = r_x_bcd;
  assign io_bus.y_bcd    = r_y_bcd;
  assign io_bus.x_out    = r_x_out;
  assign io_bus.y_out    = r_y_out;
  assign io_bus.sat      = r_sat;
  assign io_bus.valid    = (r_state == ST_DONE);
  assign io_bus.busy     = (r_state != ST_IDLE);

endmodule
